// File: rtl/gate_sequencer.sv
// gate_sequencer: pattern step sequencer driving a voice's envelope gate and note
module gate_sequencer #(
  parameter int STEPS   = 16,
  parameter int TEMPO_W = 16
) (
  input  logic               sample_clock,
  input  logic               rst,
  input  logic               run,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic [7:0]         gate_len,
  input  logic [4:0]         length,
  input  logic               wr_en,
  input  logic [3:0]         wr_addr,
  input  logic [8:0]         wr_data,
  output logic               gate,
  output logic [7:0]         note,
  output logic [3:0]         step,
  output logic               step_strobe
);
  localparam logic [4:0] MAX_LEN = 5'(STEPS);
  localparam int PW = TEMPO_W + 8;
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state_q, state_d;
  logic [8:0] pat_q [16];
  logic [8:0] pat_d [16];
  logic [TEMPO_W-1:0] k_q, k_d, t_q, t_d, on_q, on_d;
  logic e_q, e_d, gate_q, gate_d, strobe_q, strobe_d;
  logic [7:0] note_q, note_d;
  logic [3:0] step_q, step_d;
  logic [4:0] eff_len, step_inc;
  logic [3:0] next_step, start_step;
  logic [8:0] entry;
  logic [TEMPO_W-1:0] t_new, on_new, k_inc;
  logic [PW-1:0] prod;
  logic start;
  always_comb begin
    eff_len = (length == 5'd0 || length > MAX_LEN) ? MAX_LEN : length;
    step_inc = {1'b0, step_q} + 5'd1;
    next_step = (step_inc >= eff_len) ? 4'd0 : step_inc[3:0];
    start_step = (state_q == IDLE) ? 4'd0 : next_step;
    entry = pat_q[start_step];
    start = run && (state_q == IDLE || k_q == t_q - 1'b1);
    t_new = (tempo < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo;
    // T*(G+1) kept at full width so the >>8 sees every product bit
    prod = PW'(t_new) * PW'(gate_len) + PW'(t_new);
    on_new = TEMPO_W'(prod >> 8);
    k_inc = k_q + 1'b1;
    pat_d = pat_q;
    if (wr_en && {1'b0, wr_addr} < MAX_LEN) pat_d[wr_addr] = wr_data;
    state_d = state_q;
    k_d = k_q;
    t_d = t_q;
    on_d = on_q;
    e_d = e_q;
    note_d = note_q;
    step_d = step_q;
    gate_d = 1'b0;
    strobe_d = 1'b0;
    if (!run) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = PLAY;
      k_d = '0;
      step_d = start_step;
      t_d = t_new;
      on_d = on_new;
      e_d = entry[8];
      note_d = entry[7:0];
      strobe_d = 1'b1;
      gate_d = entry[8] && on_new != '0;
    end else begin
      k_d = k_inc;
      gate_d = e_q && k_inc < on_q && k_inc < t_q - 1'b1;
    end
  end
  always_ff @(posedge sample_clock) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q <= '{default: '0};
      k_q <= '0;
      t_q <= '0;
      on_q <= '0;
      e_q <= 1'b0;
      note_q <= '0;
      step_q <= '0;
      gate_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      k_q <= k_d;
      t_q <= t_d;
      on_q <= on_d;
      e_q <= e_d;
      note_q <= note_d;
      step_q <= step_d;
      gate_q <= gate_d;
      strobe_q <= strobe_d;
    end
  end
  assign gate = gate_q;
  assign note = note_q;
  assign step = step_q;
  assign step_strobe = strobe_q;
endmodule

// File: tb/tb_gate_sequencer.sv
// tb_gate_sequencer: directed and randomized checks of gate_sequencer against an elapsed-time model
module tb_gate_sequencer;
  logic sample_clock = 1'b0;
  logic rst = 1'b1, run = 1'b0, wr_en = 1'b0;
  logic [15:0] tempo = 16'd4;
  logic [7:0] gate_len = 8'd128;
  logic [4:0] length = 5'd0;
  logic [3:0] wr_addr = 4'd0;
  logic [8:0] wr_data = 9'd0;
  logic gate, step_strobe;
  logic [7:0] note;
  logic [3:0] step;
  int checks = 0, errors = 0;
  bit m_play, m_e, m_gate, m_strobe;
  int m_n = 0, m_s = 0, m_t = 2, m_on = 0, m_step = 0;
  logic [7:0] m_note = 8'd0;
  logic [8:0] m_pat [16];

  gate_sequencer dut (
    .sample_clock(sample_clock), .rst(rst), .run(run), .tempo(tempo),
    .gate_len(gate_len), .length(length), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .gate(gate), .note(note), .step(step),
    .step_strobe(step_strobe)
  );

  always #5 sample_clock = ~sample_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Reference: steps measured as elapsed cycles since the step began
  task automatic model();
    int len, k;
    m_n++;
    if (rst) begin
      m_play = 0; m_step = 0; m_note = 8'd0; m_gate = 0; m_strobe = 0; m_e = 0;
      for (int i = 0; i < 16; i++) m_pat[i] = 9'd0;
      return;
    end
    len = (length == 0 || length > 16) ? 16 : int'(length);
    if (!run) m_play = 0;
    else if (!m_play || m_n - m_s == m_t) begin
      m_step = m_play ? ((m_step + 1 >= len) ? 0 : m_step + 1) : 0;
      m_play = 1;
      m_s = m_n;
      m_t = (tempo < 2) ? 2 : int'(tempo);
      m_on = (m_t * (int'(gate_len) + 1)) >> 8;
      m_e = m_pat[m_step][8];
      m_note = m_pat[m_step][7:0];
    end
    if (wr_en) m_pat[wr_addr] = wr_data;
    k = m_n - m_s;
    m_gate = m_play && m_e && k < m_on && k < m_t - 1;
    m_strobe = m_play && k == 0;
  endtask

  function automatic logic [13:0] m_vec();
    return {m_gate, m_note, 4'(m_step), m_strobe};
  endfunction

  task automatic tick();
    @(posedge sample_clock);
    model();
    #1;
  endtask

  task automatic write_pat(input logic [3:0] a, input logic [8:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int hi = 0;
    rst = 1'b1; run = 1'b0;
    tick(); tick();
    if ({gate, note, step, step_strobe} !== 14'h0) begin
      errors++; $display("FAIL reset: got %h exp 0000", {gate, note, step, step_strobe});
    end
    checks++;
    rst = 1'b0; tempo = 16'd4; gate_len = 8'd255; length = 5'd0; run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      hi += int'(gate);
      if ({gate, note, step, step_strobe} !== m_vec()) begin
        errors++; $display("FAIL empty_pattern cyc=%0d got %h exp %h", m_n, {gate, note, step, step_strobe}, m_vec());
      end
      checks++;
    end
    if (hi != 0 || step !== 4'd9) begin
      errors++; $display("FAIL empty_advance: got gates=%0d step=%0d exp gates=0 step=9", hi, step);
    end
    checks++;
  endtask

  task automatic test_gate_duty();
    int hi = 0, st = 0;
    run = 1'b0;
    write_pat(4'd0, {1'b1, 8'h3C});
    tempo = 16'd8; gate_len = 8'd127; length = 5'd1; run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      hi += int'(gate); st += int'(step_strobe);
      if ({gate, note, step, step_strobe} !== m_vec() || note !== 8'h3C) begin
        errors++; $display("FAIL duty cyc=%0d got %h exp %h note 3c", m_n, {gate, note, step, step_strobe}, m_vec());
      end
      checks++;
    end
    if (hi != 8 || st != 2) begin
      errors++; $display("FAIL duty_count: got gates=%0d strobes=%0d exp 8 2", hi, st);
    end
    checks++;
  endtask

  task automatic test_forced_drop();
    int hi = 0, st = 0;
    run = 1'b0; tick();
    tempo = 16'd8; gate_len = 8'd255; run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      hi += int'(gate); st += int'(step_strobe);
      if ({gate, note, step, step_strobe} !== m_vec()) begin
        errors++; $display("FAIL drop cyc=%0d got %h exp %h", m_n, {gate, note, step, step_strobe}, m_vec());
      end
      checks++;
    end
    if (hi != 14 || st != 2) begin
      errors++; $display("FAIL drop_count: got gates=%0d strobes=%0d exp 14 2", hi, st);
    end
    checks++;
    hi = 0; st = 0;
    run = 1'b0; tick();
    tempo = 16'd1; run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      hi += int'(gate); st += int'(step_strobe);
      if ({gate, note, step, step_strobe} !== m_vec()) begin
        errors++; $display("FAIL tempo1 cyc=%0d got %h exp %h", m_n, {gate, note, step, step_strobe}, m_vec());
      end
      checks++;
    end
    if (hi != 8 || st != 8) begin
      errors++; $display("FAIL tempo1_count: got gates=%0d strobes=%0d exp 8 8", hi, st);
    end
    checks++;
  endtask

  task automatic test_wrap();
    int n = 0;
    run = 1'b0;
    for (int i = 0; i < 16; i++) write_pat(4'(i), 9'($urandom));
    tempo = 16'd4; gate_len = 8'($urandom); length = 5'd3; run = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if ({gate, note, step, step_strobe} !== m_vec() || (step_strobe && step !== 4'(n % 3))) begin
        errors++; $display("FAIL wrap3 cyc=%0d got %h exp %h", m_n, {gate, note, step, step_strobe}, m_vec());
      end
      checks++;
      n += int'(step_strobe);
    end
    if (n != 6) begin
      errors++; $display("FAIL wrap3_strobes: got %0d exp 6", n);
    end
    checks++;
    n = 0; run = 1'b0; tick();
    length = 5'd0; run = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if ({gate, note, step, step_strobe} !== m_vec() || (step_strobe && step !== 4'(n % 16))) begin
        errors++; $display("FAIL wrap16 cyc=%0d got %h exp %h", m_n, {gate, note, step, step_strobe}, m_vec());
      end
      checks++;
      n += int'(step_strobe);
    end
    if (n != 16) begin
      errors++; $display("FAIL wrap16_strobes: got %0d exp 16", n);
    end
    checks++;
    run = 1'b0; tick();
    length = 5'd16; run = 1'b1;
    for (int i = 0; i < 37; i++) tick();
    if (step !== 4'd9 || step_strobe !== 1'b1) begin
      errors++; $display("FAIL at_step9: got step=%0d strobe=%0b exp 9 1", step, step_strobe);
    end
    checks++;
    length = 5'd3;
    for (int i = 0; i < 4; i++) tick();
    if (step !== 4'd0 || step_strobe !== 1'b1 || {gate, note, step, step_strobe} !== m_vec()) begin
      errors++; $display("FAIL shrink: got step=%0d strobe=%0b exp 0 1", step, step_strobe);
    end
    checks++;
  endtask

  task automatic test_stop_restart();
    run = 1'b0;
    write_pat(4'd5, {1'b1, 8'h45});
    length = 5'd0; tempo = 16'd8; gate_len = 8'd255; run = 1'b1;
    for (int i = 0; i < 43; i++) tick();
    if (gate !== 1'b1 || step !== 4'd5) begin
      errors++; $display("FAIL pre_stop: got gate=%0b step=%0d exp 1 5", gate, step);
    end
    checks++;
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({gate, note, step, step_strobe} !== {1'b0, 8'h45, 4'd5, 1'b0} || m_vec() !== {1'b0, 8'h45, 4'd5, 1'b0}) begin
        errors++; $display("FAIL stopped cyc=%0d got %h exp %h", m_n, {gate, note, step, step_strobe}, {1'b0, 8'h45, 4'd5, 1'b0});
      end
      checks++;
    end
    run = 1'b1; tick();
    if (step_strobe !== 1'b1 || step !== 4'd0 || {gate, note, step, step_strobe} !== m_vec()) begin
      errors++; $display("FAIL restart: got strobe=%0b step=%0d exp 1 0", step_strobe, step);
    end
    checks++;
  endtask

  task automatic test_writes();
    run = 1'b0;
    write_pat(4'd1, 9'h000);
    length = 5'd0; tempo = 16'd6; gate_len = 8'd200; run = 1'b1;
    tick();
    write_pat(4'd1, {1'b1, 8'h55});
    for (int i = 0; i < 5; i++) tick();
    if ({gate, note, step, step_strobe} !== {1'b1, 8'h55, 4'd1, 1'b1} || m_vec() !== {1'b1, 8'h55, 4'd1, 1'b1}) begin
      errors++; $display("FAIL write_ahead: got %h exp %h", {gate, note, step, step_strobe}, {1'b1, 8'h55, 4'd1, 1'b1});
    end
    checks++;
    run = 1'b0; tick();
    run = 1'b1; tick();
    for (int i = 0; i < 5; i++) tick();
    write_pat(4'd1, {1'b1, 8'h77});
    if (note !== 8'h55 || step !== 4'd1 || {gate, note, step, step_strobe} !== m_vec()) begin
      errors++; $display("FAIL same_edge: got note=%h step=%0d exp note=55 step=1", note, step);
    end
    checks++;
    for (int i = 0; i < 96; i++) begin
      tick();
      if ({gate, note, step, step_strobe} !== m_vec()) begin
        errors++; $display("FAIL lap cyc=%0d got %h exp %h", m_n, {gate, note, step, step_strobe}, m_vec());
      end
      checks++;
    end
    if (note !== 8'h77 || step !== 4'd1) begin
      errors++; $display("FAIL new_lap: got note=%h step=%0d exp note=77 step=1", note, step);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int hi = 0;
    run = 1'b0;
    for (int i = 0; i < 16; i++) write_pat(4'(i), {1'b1, 8'(i + 1)});
    tempo = 16'd8; gate_len = 8'd255; length = 5'd0; run = 1'b1;
    tick(); tick();
    if (gate !== 1'b1) begin
      errors++; $display("FAIL pre_reset_gate: got %0b exp 1", gate);
    end
    checks++;
    rst = 1'b1; tick();
    if ({gate, note, step, step_strobe} !== 14'h0) begin
      errors++; $display("FAIL reset_mid: got %h exp 0000", {gate, note, step, step_strobe});
    end
    checks++;
    rst = 1'b0; tempo = 16'd4;
    for (int i = 0; i < 70; i++) begin
      tick();
      hi += int'(gate);
      if ({gate, note, step, step_strobe} !== m_vec() || note !== 8'h00) begin
        errors++; $display("FAIL cleared cyc=%0d got %h exp %h", m_n, {gate, note, step, step_strobe}, m_vec());
      end
      checks++;
    end
    if (hi != 0) begin
      errors++; $display("FAIL cleared_gates: got %0d exp 0", hi);
    end
    checks++;
  endtask

  task automatic test_random();
    run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 19) == 0) tempo = 16'($urandom_range(0, 10));
      if ($urandom_range(0, 9) == 0) gate_len = 8'($urandom);
      if ($urandom_range(0, 29) == 0) length = 5'($urandom_range(0, 31));
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 4'($urandom);
      wr_data = 9'($urandom);
      tick();
      if ({gate, note, step, step_strobe} !== m_vec()) begin
        errors++; $display("FAIL random cyc=%0d got %h exp %h", m_n, {gate, note, step, step_strobe}, m_vec());
      end
      checks++;
    end
    rst = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_pat[i] = 9'd0;
    test_reset();
    test_gate_duty();
    test_forced_drop();
    test_wrap();
    test_stop_restart();
    test_writes();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
